// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the piso_tx serial transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int WIDTH_DEF = 4;

    // Counter width; a two-bit word still needs one counter bit.
    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_tx_bit_counter.sv
// Bit position counter for piso_tx: clear has priority over count enable,
// tc flags the final bit position of a word.
module bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = cnt_w(WIDTH);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: accepts a word on load&ready and sends
// it LSB first, one bit per enabled cycle, streaming back-to-back words.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] pi,
    input  logic             load,
    input  logic             en,
    output logic             ready,
    output logic             so,
    output logic             sv,
    output logic             busy,
    output logic             done
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;

    logic tc;
    logic shifting;
    logic last;
    logic accept;

    assign shifting = (state_q == SHIFT) && en;
    assign last     = shifting && tc;
    // ready opens during the last bit so the next word follows without a gap.
    assign ready    = (state_q == IDLE) || last;
    assign accept   = load && ready;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        if (accept) begin
            sreg_d  = pi;
            state_d = SHIFT;
        end else if (shifting) begin
            sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
            if (last) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
        end
    end

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .resetn (resetn),
        .clr    (accept || last),
        .en     (shifting),
        .tc     (tc)
    );

    assign busy = (state_q == SHIFT);
    assign so   = busy && sreg_q[0];
    assign sv   = shifting;
    assign done = last;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: vector table plus reset and loopback sequences.
module tb_piso_tx;

    logic       clk;
    logic       resetn;
    logic [3:0] pi;
    logic       load;
    logic       en;
    logic       ready;
    logic       so;
    logic       sv;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    logic [3:0] rx;

    typedef struct {
        logic       load;
        logic [3:0] pi;
        logic       en;
        logic [4:0] exp; // {ready, so, sv, busy, done}
    } vec_t;

    vec_t tbl[$];

    piso_tx #(.WIDTH(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .pi     (pi),
        .load   (load),
        .en     (en),
        .ready  (ready),
        .so     (so),
        .sv     (sv),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference SIPO receiver: shifts so in from the top when sv is high.
    always @(posedge clk) begin
        if (sv) rx <= {so, rx[3:1]};
    end

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {rdy,so,sv,busy,done}=%b, expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic l, input logic [3:0] p, input logic e, input logic [4:0] x);
        vec_t v;
        v.load = l; v.pi = p; v.en = e; v.exp = x;
        tbl.push_back(v);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rx     = 4'b0;
        load   = 1'b0;
        pi     = 4'b0;
        en     = 1'b0;

        // Single word 1011 -> 1,1,0,1
        add(1, 4'b1011, 1, 5'b10000);
        add(0, 4'b0000, 1, 5'b01110);
        add(0, 4'b0000, 1, 5'b01110);
        add(0, 4'b0000, 1, 5'b00110);
        add(0, 4'b0000, 1, 5'b11111);
        add(0, 4'b0000, 1, 5'b10000);
        // Back-to-back 0110 then 1001, second load during done
        add(1, 4'b0110, 1, 5'b10000);
        add(0, 4'b0000, 1, 5'b00110);
        add(0, 4'b0000, 1, 5'b01110);
        add(0, 4'b0000, 1, 5'b01110);
        add(1, 4'b1001, 1, 5'b10111);
        add(0, 4'b0000, 1, 5'b01110);
        add(0, 4'b0000, 1, 5'b00110);
        add(0, 4'b0000, 1, 5'b00110);
        add(0, 4'b0000, 1, 5'b11111);
        add(0, 4'b0000, 1, 5'b10000);
        // Stall after bit 1 of 1100; load during stall is refused
        add(1, 4'b1100, 1, 5'b10000);
        add(0, 4'b0000, 1, 5'b00110);
        add(0, 4'b0000, 1, 5'b00110);
        add(1, 4'b0101, 0, 5'b01010);
        add(0, 4'b0000, 0, 5'b01010);
        add(0, 4'b0000, 1, 5'b01110);
        add(0, 4'b0000, 1, 5'b11111);
        add(0, 4'b0000, 1, 5'b10000);
        // 0001 with load of 1111 held from bit 2; taken only at done
        add(1, 4'b0001, 1, 5'b10000);
        add(0, 4'b0000, 1, 5'b01110);
        add(0, 4'b0000, 1, 5'b00110);
        add(1, 4'b1111, 1, 5'b00110);
        add(1, 4'b1111, 1, 5'b10111);
        add(0, 4'b0000, 1, 5'b01110);
        add(0, 4'b0000, 1, 5'b01110);
        add(0, 4'b0000, 1, 5'b01110);
        add(0, 4'b0000, 1, 5'b11111);
        add(0, 4'b0000, 1, 5'b10000);

        resetn = 1'b0;
        #12;
        chk("reset_state", {ready, so, sv, busy, done}, 5'b10000);
        @(posedge clk);
        #1 resetn = 1'b1;

        foreach (tbl[i]) begin
            load = tbl[i].load;
            pi   = tbl[i].pi;
            en   = tbl[i].en;
            @(negedge clk);
            chk($sformatf("vec%0d", i), {ready, so, sv, busy, done}, tbl[i].exp);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of a word
        load = 1'b1; pi = 4'b1011; en = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        chk("reset_mid_xfer", {ready, so, sv, busy, done}, 5'b10000);
        @(posedge clk); #1;
        resetn = 1'b1;
        begin
            logic [1:0] seen;
            seen = 2'b00;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                seen = seen | {done, busy};
                @(posedge clk); #1;
            end
            chk("no_done_after_reset", {3'b0, seen}, 5'b00000);
        end

        // Loopback of all 16 words through the reference receiver
        for (int w = 0; w < 16; w++) begin
            int  n;
            logic got;
            load = 1'b1; pi = 4'(w); en = 1'b1;
            @(posedge clk); #1;
            load = 1'b0; pi = 4'b0;
            n = 0; got = 1'b0;
            while (!got && n < 10) begin
                @(negedge clk);
                if (done) got = 1'b1;
                @(posedge clk); #1;
                n++;
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL loop%0d_timeout: done not seen within 10 cycles, expected pulse", w);
            end else begin
                chk($sformatf("loop%0d_rx", w), {1'b0, rx}, {1'b0, 4'(w)});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in/serial-out transmitter for the serial link whose receiving end is a SIPO shift register. It accepts a WIDTH-bit word through a ready/load handshake and shifts it out LSB first, one bit per enabled clock. A strobe qualifies each bit, and a done pulse marks the last bit. Because bit 0 goes first, the receiver's 4-bit parallel output equals the transmitted word after WIDTH shifts. Consecutive words stream with no gap.

## Interface
- WIDTH, 4, word length in bits (≥2)
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- pi  in  WIDTH  parallel word to transmit
- load  in  1  request to transmit pi; accepted only when ready=1
- en  in  1  shift enable; 0 stalls the transfer
- ready  out  1  transmitter can accept a word this cycle
- so  out  1  serial data
- sv  out  1  so carries a valid bit this cycle
- busy  out  1  transfer in progress (state SHIFT)
- done  out  1  single-cycle pulse coincident with the last bit of a word

## Operation
- Registers: state (IDLE, SHIFT), sreg[WIDTH-1:0], cnt[$clog2(WIDTH)-1:0].
- last = (state==SHIFT) & en & (cnt==WIDTH-1).
- IDLE:
  - ready=1, so=0, sv=0, busy=0.
  - load=1 → sreg←pi, cnt←0, state←SHIFT.
- SHIFT, en=1:
  - so=sreg[0], sv=1.
  - sreg←{1'b0, sreg[WIDTH-1:1]}, cnt←cnt+1.
- SHIFT, en=0: all registers hold; sv=0; so=sreg[0] (don't-care to receiver).
- On last:
  - done=1, ready=1.
  - If load=1 → sreg←pi, cnt←0, stay in SHIFT (back-to-back).
  - Otherwise state←IDLE, cnt←0.
- ready = (state==IDLE) | last. This is combinational on en; the driver must not make load depend on ready combinationally.
- load while ready=0 is ignored. The word is not latched; the sender holds load/pi until it sees ready.
- pi is sampled only at the accepting edge; later changes to pi do not affect the word in flight.
- busy = (state==SHIFT), including stalled cycles and the last-bit cycle.
- Counter wrap: cnt never exceeds WIDTH-1; it is reset to 0 on every accept and on return to IDLE.

## Timing
- Reset (resetn=0, asynchronous, any state): state=IDLE, sreg=0, cnt=0. Outputs: ready=1, so=0, sv=0, busy=0, done=0.
- Reset mid-transfer discards the word. No done pulse is issued for it.
- First accept is possible on the first rising edge after resetn deasserts.
- Latency, with a word accepted at edge k and en=1 throughout:
  - bit i is on so with sv=1 during cycle k+1+i, for i=0..WIDTH-1;
  - done=1 during cycle k+WIDTH.
- Each en=0 cycle in SHIFT delays all remaining bits by one cycle.
- Throughput: one bit per enabled cycle. Back-to-back words have zero idle bits between them.
- Simultaneous load and last: the new word's bit 0 appears in the very next cycle.
- Simultaneous load and en=0 in SHIFT: not accepted (ready=0).
- Receiver alignment: a SIPO clocked with so gated by sv presents pi on its parallel output after the edge ending cycle k+WIDTH.

## Structure
- Package piso_pkg:
  - state enum typedef (IDLE, SHIFT);
  - WIDTH default constant;
  - counter-width function.
- Sub-module bit_counter: cnt register with clear, enable and terminal-count (cnt==WIDTH-1) output, sharing clk/resetn.
- Shift register, FSM and output logic stay in piso_tx.

## Test plan
- Reset: drive resetn=0 mid-transfer with pi=4'b1011 → immediately ready=1, so=0, sv=0, busy=0, done=0; no done pulse follows.
- Single word: pi=4'b1011, load for one cycle, en=1 → so sequence 1,1,0,1 with sv=1 for 4 cycles; done high on the 4th bit; then IDLE.
- Back-to-back: 4'b0110 then 4'b1001, second load asserted during the done cycle → 8 contiguous sv=1 cycles, so=0,1,1,0,1,0,0,1, two done pulses 4 cycles apart.
- Stall: pi=4'b1100, en=0 for 2 cycles after bit 1 → sv low for those 2 cycles, bits still 0,0,1,1, done delayed by exactly 2 cycles, busy stays high.
- Load ignored: assert load with pi=4'b1111 during bit 2 of 4'b0001 → transmitted stream stays 1,0,0,0; 4'b1111 is taken only if load is still high at done.
- Loopback: connect so/sv to a SIPO receiver and send all 16 values of pi → the receiver's parallel output equals each word one edge after its done pulse.
